rgb_led_sequencer: RTL and testbench

Parametrised multi-channel LED pattern engine: drives `CHANNELS` PWM outputs with selectable patterns (off, rotating one-hot, breathing, solid) at programmable brightness. It sits between the board's control logic and the on-chip RGB LED current driver; each `pwm[i]` connects to that driver's per-channel PWM input. It replaces the fixed 1-of-3 rotator and adds duty-cycle control, a breathing mode and an arbitrary channel count.

---
 rtl/led_seq_pkg.sv | 26 ++
 rtl/led_pwm_channel.sv | 24 ++
 rtl/rgb_led_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_rgb_led_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the RGB LED pattern engine.
package led_seq_pkg;

  // Pattern selector as seen on the mode input and held in mode_q.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ROTATE  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_t;

  // Direction of the breathing ramp.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Bits needed to hold values 0..value-1 (never less than 1).
  function automatic int clog2(input int value);
    int w;
    for (w = 1; (32'd1 << w) < value; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM output: registered compare of a duty value against the shared carrier.
module led_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_ctr,
  output logic                pwm
);

  // Output is high while duty exceeds the carrier; forced low when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else if (!enable) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (duty > pwm_ctr);
    end
  end

endmodule

// File: rtl/rgb_led_sequencer.sv
// Multi-channel LED pattern engine: off, rotating one-hot, breathing and solid
// patterns with brightness scaling, driving one registered PWM output per channel.
module rgb_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 4_000_000,
  parameter int RAMP_CYCLES = 7_843
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [CHANNELS-1:0] pwm,
  output logic                step_tick
);

  localparam int STEP_W = clog2(STEP_CYCLES);
  localparam int RAMP_W = clog2(RAMP_CYCLES);
  localparam int PROD_W = 2 * PWM_BITS + 1;

  localparam logic [PWM_BITS-1:0] PWM_ZERO   = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] PWM_MAX    = {PWM_BITS{1'b1}};
  // Carrier tops out one below all-ones so that duty all-ones is always high.
  localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_MAX - PWM_ONE;
  localparam logic [STEP_W-1:0]   STEP_ZERO  = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0]   STEP_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
  localparam logic [RAMP_W-1:0]   RAMP_ZERO  = {RAMP_W{1'b0}};
  localparam logic [RAMP_W-1:0]   RAMP_ONE   = RAMP_W'(1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST  = RAMP_W'(RAMP_CYCLES - 1);
  localparam logic [CHANNELS-1:0] ONEHOT_INIT = {{(CHANNELS-1){1'b0}}, 1'b1};

  mode_t               mode_in;
  mode_t               mode_q,    mode_nxt;
  logic [PWM_BITS-1:0] pwm_ctr,   pwm_ctr_nxt;
  logic [STEP_W-1:0]   step_ctr,  step_ctr_nxt;
  logic [RAMP_W-1:0]   ramp_ctr,  ramp_ctr_nxt;
  logic [CHANNELS-1:0] onehot,    onehot_nxt;
  logic [PWM_BITS-1:0] level,     level_nxt;
  dir_t                dir,       dir_nxt;
  logic                step_tick_nxt;

  logic                restart;
  logic                step_wrap;
  logic                ramp_wrap;
  logic [PWM_BITS-1:0] pwm_ctr_adv;
  logic [STEP_W-1:0]   step_adv;
  logic [RAMP_W-1:0]   ramp_adv;
  logic [CHANNELS-1:0] onehot_rot;
  logic [PWM_BITS-1:0] level_step;
  dir_t                dir_step;
  logic [PWM_BITS:0]   bright_plus;
  logic [PROD_W-1:0]   breathe_prod;
  logic [PWM_BITS-1:0] breathe_duty;
  logic [PWM_BITS-1:0] duty [CHANNELS];

  assign mode_in     = mode_t'(mode);
  // A mode change is only honoured while running; it takes priority over any wrap.
  assign restart     = enable && (mode_in != mode_q);
  assign step_wrap   = (step_ctr == STEP_LAST);
  assign ramp_wrap   = (ramp_ctr == RAMP_LAST);
  assign pwm_ctr_adv = (pwm_ctr == PWM_LAST) ? PWM_ZERO : (pwm_ctr + PWM_ONE);
  assign step_adv    = step_wrap ? STEP_ZERO : (step_ctr + STEP_ONE);
  assign ramp_adv    = ramp_wrap ? RAMP_ZERO : (ramp_ctr + RAMP_ONE);
  assign onehot_rot  = {onehot[CHANNELS-2:0], onehot[CHANNELS-1]};

  // Triangle ramp: direction flips on the step that lands on either end.
  always_comb begin
    level_step = level;
    dir_step   = dir;
    if (dir == DIR_UP) begin
      level_step = level + PWM_ONE;
      dir_step   = (level == PWM_LAST) ? DIR_DOWN : DIR_UP;
    end else begin
      level_step = level - PWM_ONE;
      dir_step   = (level == PWM_ONE) ? DIR_UP : DIR_DOWN;
    end
  end

  // Next-state for mode, carrier, prescalers and pattern state.
  always_comb begin
    mode_nxt      = mode_q;
    pwm_ctr_nxt   = pwm_ctr;
    step_ctr_nxt  = step_ctr;
    ramp_ctr_nxt  = ramp_ctr;
    onehot_nxt    = onehot;
    level_nxt     = level;
    dir_nxt       = dir;
    step_tick_nxt = 1'b0;
    if (!enable) begin
      step_tick_nxt = 1'b0;
    end else if (restart) begin
      pwm_ctr_nxt  = pwm_ctr_adv;
      mode_nxt     = mode_in;
      step_ctr_nxt = STEP_ZERO;
      ramp_ctr_nxt = RAMP_ZERO;
      onehot_nxt   = ONEHOT_INIT;
      level_nxt    = PWM_ZERO;
      dir_nxt      = DIR_UP;
    end else begin
      pwm_ctr_nxt = pwm_ctr_adv;
      case (mode_q)
        MODE_OFF: begin
          step_ctr_nxt = STEP_ZERO;
          ramp_ctr_nxt = RAMP_ZERO;
        end
        MODE_ROTATE: begin
          step_ctr_nxt  = step_adv;
          step_tick_nxt = step_wrap;
          ramp_ctr_nxt  = RAMP_ZERO;
          onehot_nxt    = step_wrap ? onehot_rot : onehot;
        end
        MODE_BREATHE: begin
          step_ctr_nxt  = step_adv;
          step_tick_nxt = step_wrap;
          ramp_ctr_nxt  = ramp_adv;
          if (ramp_wrap) begin
            level_nxt = level_step;
            dir_nxt   = dir_step;
          end else begin
            level_nxt = level;
            dir_nxt   = dir;
          end
        end
        MODE_SOLID: begin
          step_ctr_nxt  = step_adv;
          step_tick_nxt = step_wrap;
          ramp_ctr_nxt  = RAMP_ZERO;
        end
        default: begin
          step_ctr_nxt = STEP_ZERO;
          ramp_ctr_nxt = RAMP_ZERO;
        end
      endcase
    end
  end

  // State register with asynchronous reset to the idle pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_OFF;
      pwm_ctr   <= PWM_ZERO;
      step_ctr  <= STEP_ZERO;
      ramp_ctr  <= RAMP_ZERO;
      onehot    <= ONEHOT_INIT;
      level     <= PWM_ZERO;
      dir       <= DIR_UP;
      step_tick <= 1'b0;
    end else begin
      mode_q    <= mode_nxt;
      pwm_ctr   <= pwm_ctr_nxt;
      step_ctr  <= step_ctr_nxt;
      ramp_ctr  <= ramp_ctr_nxt;
      onehot    <= onehot_nxt;
      level     <= level_nxt;
      dir       <= dir_nxt;
      step_tick <= step_tick_nxt;
    end
  end

  // Breathing duty: level scaled by (brightness+1)/2^PWM_BITS, so full brightness is exact.
  always_comb begin
    bright_plus  = {1'b0, brightness} + (PWM_BITS + 1)'(1);
    breathe_prod = {{(PWM_BITS + 1){1'b0}}, level} * {{PWM_BITS{1'b0}}, bright_plus};
    breathe_duty = PWM_BITS'(breathe_prod >> PWM_BITS);
  end

  // Per-channel duty selected by the active pattern.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty[i] = PWM_ZERO;
      case (mode_q)
        MODE_OFF:     duty[i] = PWM_ZERO;
        MODE_ROTATE:  duty[i] = onehot[i] ? brightness : PWM_ZERO;
        MODE_BREATHE: duty[i] = breathe_duty;
        MODE_SOLID:   duty[i] = brightness;
        default:      duty[i] = PWM_ZERO;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .duty    (duty[g]),
      .pwm_ctr (pwm_ctr),
      .pwm     (pwm[g])
    );
  end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Self-checking bench for rgb_led_sequencer: vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_rgb_led_sequencer;

  localparam int CH  = 3;
  localparam int PB  = 4;
  localparam int SC  = 10;
  localparam int RC  = 2;
  localparam int CAR = 15;            // carrier period 2^PB-1
  localparam int TRI = 2 * CAR;       // breathing period in ramp ticks

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [PB-1:0] brightness = 4'd0;
  logic [CH-1:0] pwm;
  logic          step_tick;

  int tests = 0;
  int fails = 0;

  // Model state: abstract counts rather than hardware registers.
  int       m_mode, m_pc, m_sc, m_rc, m_bt, m_idx;
  logic [CH-1:0] m_pwm;
  logic     m_tick;

  rgb_led_sequencer #(
    .CHANNELS    (CH),
    .PWM_BITS    (PB),
    .STEP_CYCLES (SC),
    .RAMP_CYCLES (RC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .brightness (brightness),
    .pwm        (pwm),
    .step_tick  (step_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    md;
    logic [PB-1:0] br;
    int            n;
    logic [CH-1:0] exp_pwm;
    int            exp_ticks;
  } vec_t;

  vec_t vecs[12];

  // Breathing level after t ramp ticks: triangle wave 0..15..0.
  function automatic int tri_level(input int t);
    int p;
    p = t % TRI;
    return (p <= CAR) ? p : TRI - p;
  endfunction

  function automatic int duty_of(input int ch, input int md, input int br,
                                 input int idx, input int lvl);
    case (md)
      1:       return (ch == idx) ? br : 0;
      2:       return (lvl * (br + 1)) / (1 << PB);
      3:       return br;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_sc = 0; m_rc = 0; m_bt = 0; m_idx = 0;
    m_pwm = '0; m_tick = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at that edge.
  task automatic model_step();
    if (!enable) begin
      m_pwm  = '0;
      m_tick = 1'b0;
    end else begin
      for (int c = 0; c < CH; c++)
        m_pwm[c] = (duty_of(c, m_mode, int'(brightness), m_idx, tri_level(m_bt)) > m_pc);
      m_tick = 1'b0;
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode);
        m_sc = 0; m_rc = 0; m_bt = 0; m_idx = 0;
      end else if (m_mode != 0) begin
        if (m_sc == SC - 1) begin
          m_sc = 0;
          m_tick = 1'b1;
          if (m_mode == 1) m_idx = (m_idx + 1) % CH;
        end else begin
          m_sc++;
        end
        if (m_mode == 2) begin
          if (m_rc == RC - 1) begin
            m_rc = 0;
            m_bt++;
          end else begin
            m_rc++;
          end
        end
      end
      m_pc = (m_pc + 1) % CAR;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("pwm", {29'd0, pwm}, {29'd0, m_pwm});
    check("step_tick", {31'd0, step_tick}, {31'd0, m_tick});
  endtask

  task automatic do_reset(input logic en, input logic [1:0] md, input logic [PB-1:0] br);
    rst_n = 1'b0;
    enable = en;
    mode = md;
    brightness = br;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pwm", {29'd0, pwm}, 32'd0);
    check("reset_tick", {31'd0, step_tick}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int ticks;
    int cnt;
    int n;

    vecs[0]  = '{2'd1, 4'd15, 1,  3'b000, 0};
    vecs[1]  = '{2'd1, 4'd15, 2,  3'b001, 0};
    vecs[2]  = '{2'd1, 4'd15, 12, 3'b010, 1};
    vecs[3]  = '{2'd1, 4'd15, 22, 3'b100, 2};
    vecs[4]  = '{2'd1, 4'd15, 32, 3'b001, 3};
    vecs[5]  = '{2'd1, 4'd0,  15, 3'b000, 1};
    vecs[6]  = '{2'd2, 4'd15, 2,  3'b000, 0};
    vecs[7]  = '{2'd2, 4'd15, 32, 3'b111, 3};
    vecs[8]  = '{2'd2, 4'd7,  32, 3'b111, 3};
    vecs[9]  = '{2'd3, 4'd15, 2,  3'b111, 0};
    vecs[10] = '{2'd3, 4'd15, 40, 3'b111, 3};
    vecs[11] = '{2'd0, 4'd15, 20, 3'b000, 0};

    // Table: each vector runs from reset with the pattern already selected.
    for (int v = 0; v < 12; v++) begin
      do_reset(1'b1, vecs[v].md, vecs[v].br);
      ticks = 0;
      repeat (vecs[v].n) begin
        cycle();
        ticks += int'(step_tick);
      end
      check($sformatf("vec%0d_pwm", v), {29'd0, pwm}, {29'd0, vecs[v].exp_pwm});
      check($sformatf("vec%0d_ticks", v), ticks, vecs[v].exp_ticks);
    end

    // ROTATE at brightness 5: exactly 5 high cycles per carrier period, one channel at a time.
    do_reset(1'b1, 2'd1, 4'd5);
    cycle();
    cnt = 0;
    repeat (CAR) begin
      cycle();
      cnt += int'(|pwm);
      if ($countones(pwm) > 1) check("rot_b5_onehot", {29'd0, pwm}, 32'd1);
    end
    check("rot_b5_high_cycles", cnt, 5);

    // SOLID then OFF: low within two edges and no further ticks.
    do_reset(1'b1, 2'd3, 4'd15);
    repeat (5) cycle();
    mode = 2'd0;
    repeat (2) cycle();
    check("off_pwm", {29'd0, pwm}, 32'd0);
    ticks = 0;
    repeat (20) begin
      cycle();
      ticks += int'(step_tick);
    end
    check("off_ticks", ticks, 0);

    // Freeze with enable low while channel 2 is lit, then resume the same step.
    do_reset(1'b1, 2'd1, 4'd15);
    repeat (23) cycle();
    check("pre_freeze_pwm", {29'd0, pwm}, 32'b100);
    enable = 1'b0;
    repeat (25) cycle();
    check("frozen_pwm", {29'd0, pwm}, 32'd0);
    enable = 1'b1;
    cycle();
    check("resume_pwm", {29'd0, pwm}, 32'b100);
    n = 1;
    while (!step_tick && n < 20) begin
      cycle();
      n++;
    end
    check("resume_tick_edges", n, 8);

    // Mode change on the wrap cycle: restart wins, no tick.
    do_reset(1'b1, 2'd1, 4'd15);
    repeat (10) cycle();
    mode = 2'd3;
    cycle();
    check("wrap_restart_tick", {31'd0, step_tick}, 32'd0);
    check("wrap_restart_pwm", {29'd0, pwm}, 32'b001);
    cycle();
    check("wrap_new_pattern", {29'd0, pwm}, 32'b111);
    n = 1;
    while (!step_tick && n < 20) begin
      cycle();
      n++;
    end
    check("restart_tick_edges", n, 10);

    // Asynchronous reset mid-breathe clears outputs without a clock edge.
    do_reset(1'b1, 2'd2, 4'd15);
    repeat (26) cycle();
    check("pre_reset_breathe", {29'd0, pwm}, 32'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pwm", {29'd0, pwm}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cycle();
    check("post_reset_level0", {29'd0, pwm}, 32'd0);

    // Randomized run against the model.
    do_reset(1'b1, 2'd1, 4'd15);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) brightness = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1'b1, mode, brightness);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
